// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with a valid/ready issue handshake.
// Base ops (including SLT/SLTU) complete in one cycle. RV32M multiply and
// divide ops run on a shared iterative radix-2 datapath: shift-add for
// multiply and restoring division, one bit per cycle.
//
// Op encoding on i_aluop:
//   [4]=0 : 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 XOR, 6 OR, 7 AND,
//           8 PASS, 9 SLT, 10 SLTU, 11..15 illegal (result 0)
//   [4]=1 : [2:0] = funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
module alu_muldiv #(
  parameter int DWIDTH      = 32,
  parameter int ALUOP_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DWIDTH-1:0]      i_op1,
  input  logic [DWIDTH-1:0]      i_op2,
  input  logic [ALUOP_WIDTH-1:0] i_aluop,
  output logic                   o_valid,
  output logic [DWIDTH-1:0]      o_result
);

  localparam int SHW = $clog2(DWIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;

  localparam logic [SHW-1:0]    LAST_STEP = SHW'(DWIDTH - 1);
  localparam logic [DWIDTH-1:0] SIGN_MIN  = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state_q, state_d;
  logic [SHW-1:0]      count_q, count_d;
  logic [2*DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0]   opB_q, opB_d;
  logic [2:0]          func_q, func_d;
  logic                neg_q, neg_d;
  logic [DWIDTH-1:0]   result_q, result_d;
  logic                valid_q, valid_d;

  logic [SHW-1:0]      shamt;
  logic [DWIDTH-1:0]   baseResult;

  logic [2:0]          inFunc;
  logic                signed1, signed2, neg1, neg2;
  logic [DWIDTH-1:0]   mag1, mag2;
  logic                isDivIn, isRemIn, divZero, divOvf;
  logic [DWIDTH-1:0]   fastResult;

  logic [DWIDTH:0]     mulSum;
  logic [2*DWIDTH-1:0] mulNext;
  logic [DWIDTH:0]     remShift;
  logic [DWIDTH-1:0]   remDiff;
  logic [2*DWIDTH-1:0] divNext;

  logic [2*DWIDTH-1:0] accSigned;
  logic [DWIDTH-1:0]   quoMag, remMag;
  logic [DWIDTH-1:0]   fixResult;

  assign shamt    = i_op2[SHW-1:0];
  assign o_ready  = (state_q == IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;

  // Single-cycle base operations, computed straight from the issue inputs.
  always_comb begin
    baseResult = '0;
    case (i_aluop[3:0])
      OP_ADD:  baseResult = i_op1 + i_op2;
      OP_SUB:  baseResult = i_op1 - i_op2;
      OP_SLL:  baseResult = i_op1 << shamt;
      OP_SRL:  baseResult = i_op1 >> shamt;
      OP_SRA:  baseResult = $unsigned($signed(i_op1) >>> shamt);
      OP_XOR:  baseResult = i_op1 ^ i_op2;
      OP_OR:   baseResult = i_op1 | i_op2;
      OP_AND:  baseResult = i_op1 & i_op2;
      OP_PASS: baseResult = i_op2;
      OP_SLT:  baseResult = {{(DWIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      OP_SLTU: baseResult = {{(DWIDTH-1){1'b0}}, (i_op1 < i_op2)};
      default: baseResult = '0;
    endcase
  end

  // Operand preparation for M ops: signedness, magnitudes and the special cases
  // (divide by zero, signed overflow) that bypass the iterative datapath.
  always_comb begin
    inFunc     = i_aluop[2:0];
    signed1    = (inFunc == F_MULH) || (inFunc == F_MULHSU) ||
                 (inFunc == F_DIV)  || (inFunc == F_REM);
    signed2    = (inFunc == F_MULH) || (inFunc == F_DIV) || (inFunc == F_REM);
    neg1       = signed1 & i_op1[DWIDTH-1];
    neg2       = signed2 & i_op2[DWIDTH-1];
    mag1       = neg1 ? -i_op1 : i_op1;
    mag2       = neg2 ? -i_op2 : i_op2;
    isDivIn    = inFunc[2];
    isRemIn    = inFunc[2] & inFunc[1];
    divZero    = isDivIn && (i_op2 == '0);
    divOvf     = isDivIn && signed2 && (i_op1 == SIGN_MIN) && (i_op2 == '1);
    fastResult = '0;
    if (divZero) begin
      fastResult = isRemIn ? i_op1 : '1;
    end else if (divOvf) begin
      fastResult = isRemIn ? '0 : i_op1;
    end
  end

  // One iteration of shift-add multiply and of restoring division on acc_q.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + {1'b0, opB_q & {DWIDTH{acc_q[0]}}};
    mulNext  = {mulSum, acc_q[DWIDTH-1:1]};
    remShift = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-1]};
    remDiff  = remShift[DWIDTH-1:0] - opB_q;
    if (remShift >= {1'b0, opB_q}) begin
      divNext = {remDiff, acc_q[DWIDTH-2:0], 1'b1};
    end else begin
      divNext = {remShift[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b0};
    end
  end

  // Final sign correction and half selection once the iterations are done.
  always_comb begin
    accSigned = neg_q ? -acc_q : acc_q;
    quoMag    = acc_q[DWIDTH-1:0];
    remMag    = acc_q[2*DWIDTH-1:DWIDTH];
    fixResult = '0;
    case (func_q)
      F_MUL:                     fixResult = accSigned[DWIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU: fixResult = accSigned[2*DWIDTH-1:DWIDTH];
      F_DIV, F_DIVU:             fixResult = neg_q ? -quoMag : quoMag;
      default:                   fixResult = neg_q ? -remMag : remMag;
    endcase
  end

  // Control FSM and next-state for all datapath registers.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opB_d    = opB_q;
    func_d   = func_q;
    neg_d    = neg_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (!i_aluop[4]) begin
            result_d = baseResult;
            valid_d  = 1'b1;
          end else if (divZero || divOvf) begin
            result_d = fastResult;
            valid_d  = 1'b1;
          end else begin
            state_d = RUN;
            count_d = '0;
            func_d  = inFunc;
            neg_d   = isRemIn ? neg1 : (neg1 ^ neg2);
            acc_d   = {{DWIDTH{1'b0}}, (isDivIn ? mag1 : mag2)};
            opB_d   = isDivIn ? mag2 : mag1;
          end
        end
      end
      RUN: begin
        acc_d   = func_q[2] ? divNext : mulNext;
        count_d = count_q + SHW'(1);
        if (count_q == LAST_STEP) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fixResult;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opB_q    <= '0;
      func_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opB_q    <= opB_d;
      func_q   <= func_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

endmodule
